// File: rtl/qspi_boot_seq.sv
// Boot sequencer for the configuration-flash clock path: it issues the dummy CCLK
// preamble, holds the SoC in reset briefly, then hands SCK/CS to the SoC.
module qspi_boot_seq #(
    parameter int DUMMY_CLKS  = 3,
    parameter int HALF_PER    = 2,
    parameter int HOLD_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic mmcm_locked,
    input  logic soc_sck,
    input  logic soc_cs,
    output logic usr_cclk,
    output logic qspi_cs,
    output logic soc_rst_n,
    output logic seq_done
);

    // Each counter only needs to reach its own terminal value.
    localparam int HALF_W = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
    localparam int TOG_W  = $clog2(2 * DUMMY_CLKS);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_PER - 1);
    localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(2 * DUMMY_CLKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        PREAMBLE,
        HOLD,
        RUN
    } state_t;

    state_t              state;
    logic                pre_done;
    logic [HALF_W-1:0]   half_cnt;
    logic [TOG_W-1:0]    tog_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                cclk_r;
    logic                rst_n_r;
    logic                done_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_LOCK;
            pre_done <= 1'b0;
            half_cnt <= '0;
            tog_cnt  <= '0;
            hold_cnt <= '0;
            cclk_r   <= 1'b0;
            rst_n_r  <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    cclk_r <= 1'b0;
                    if (mmcm_locked)
                        state <= pre_done ? HOLD : PREAMBLE;
                end
                PREAMBLE: begin
                    if (!mmcm_locked) begin
                        // Abort leaves pre_done clear so the whole preamble replays.
                        state    <= WAIT_LOCK;
                        half_cnt <= '0;
                        tog_cnt  <= '0;
                        cclk_r   <= 1'b0;
                    end else if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        if (tog_cnt == TOG_LAST) begin
                            tog_cnt  <= '0;
                            cclk_r   <= 1'b0;
                            pre_done <= 1'b1;
                            state    <= HOLD;
                        end else begin
                            tog_cnt <= tog_cnt + TOG_W'(1);
                            cclk_r  <= ~cclk_r;
                        end
                    end else begin
                        half_cnt <= half_cnt + HALF_W'(1);
                    end
                end
                HOLD: begin
                    if (!mmcm_locked) begin
                        state    <= WAIT_LOCK;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        rst_n_r  <= 1'b1;
                        done_r   <= 1'b1;
                        state    <= RUN;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    if (!mmcm_locked) begin
                        rst_n_r <= 1'b0;
                        done_r  <= 1'b0;
                        state   <= WAIT_LOCK;
                    end
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

    // Mux select is a flop output, so ownership changes only on a clock edge.
    assign usr_cclk  = done_r ? soc_sck : cclk_r;
    assign qspi_cs   = done_r ? soc_cs  : 1'b1;
    assign soc_rst_n = rst_n_r;
    assign seq_done  = done_r;

endmodule

// File: tb/tb_qspi_boot_seq.sv
// Bench for qspi_boot_seq: default and minimal-parameter instances share stimulus and
// are compared against an elapsed-time model of the boot phases.
module tb_qspi_boot_seq;

    localparam int M_WAIT = 0;
    localparam int M_PRE  = 1;
    localparam int M_HOLD = 2;
    localparam int M_RUN  = 3;

    logic clk;
    logic reset;
    logic mmcm_locked;
    logic soc_sck;
    logic soc_cs;
    logic u1_usr_cclk, u1_qspi_cs, u1_soc_rst_n, u1_seq_done;
    logic u2_usr_cclk, u2_qspi_cs, u2_soc_rst_n, u2_seq_done;

    int total;
    int passed;

    int dc [2] = '{3, 1};
    int hp [2] = '{2, 1};
    int hc [2] = '{16, 1};
    int mode [2];
    int t [2];
    int pd [2];

    logic pat [12] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};

    qspi_boot_seq u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .mmcm_locked(mmcm_locked),
        .soc_sck    (soc_sck),
        .soc_cs     (soc_cs),
        .usr_cclk   (u1_usr_cclk),
        .qspi_cs    (u1_qspi_cs),
        .soc_rst_n  (u1_soc_rst_n),
        .seq_done   (u1_seq_done)
    );

    qspi_boot_seq #(.DUMMY_CLKS(1), .HALF_PER(1), .HOLD_CYCLES(1)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .mmcm_locked(mmcm_locked),
        .soc_sck    (soc_sck),
        .soc_cs     (soc_cs),
        .usr_cclk   (u2_usr_cclk),
        .qspi_cs    (u2_qspi_cs),
        .soc_rst_n  (u2_soc_rst_n),
        .seq_done   (u2_seq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        assert (act === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    endtask

    // Phase model: each phase is timed by cycles elapsed since entering it.
    task automatic model_edge(input logic r, input logic lk);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                mode[i] = M_WAIT; t[i] = 0; pd[i] = 0;
            end else begin
                case (mode[i])
                    M_WAIT: if (lk) begin
                        mode[i] = (pd[i] != 0) ? M_HOLD : M_PRE;
                        t[i] = 0;
                    end
                    M_PRE: if (!lk) mode[i] = M_WAIT;
                    else begin
                        t[i]++;
                        if (t[i] == 2 * dc[i] * hp[i]) begin
                            mode[i] = M_HOLD; t[i] = 0; pd[i] = 1;
                        end
                    end
                    M_HOLD: if (!lk) mode[i] = M_WAIT;
                    else begin
                        t[i]++;
                        if (t[i] == hc[i]) mode[i] = M_RUN;
                    end
                    default: if (!lk) mode[i] = M_WAIT;
                endcase
            end
        end
    endtask

    function automatic int exp_usr(input int i);
        if (mode[i] == M_RUN) return int'(soc_sck);
        if (mode[i] == M_PRE) return (t[i] / hp[i]) % 2;
        return 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " u1 usr_cclk"}, int'(u1_usr_cclk), exp_usr(0));
        chk({tag, " u1 qspi_cs"}, int'(u1_qspi_cs), (mode[0] == M_RUN) ? int'(soc_cs) : 1);
        chk({tag, " u1 soc_rst_n"}, int'(u1_soc_rst_n), int'(mode[0] == M_RUN));
        chk({tag, " u1 seq_done"}, int'(u1_seq_done), int'(mode[0] == M_RUN));
        chk({tag, " u2 usr_cclk"}, int'(u2_usr_cclk), exp_usr(1));
        chk({tag, " u2 qspi_cs"}, int'(u2_qspi_cs), (mode[1] == M_RUN) ? int'(soc_cs) : 1);
        chk({tag, " u2 soc_rst_n"}, int'(u2_soc_rst_n), int'(mode[1] == M_RUN));
        chk({tag, " u2 seq_done"}, int'(u2_seq_done), int'(mode[1] == M_RUN));
    endtask

    task automatic step(input string tag, input logic r, input logic lk, input logic sck, input logic cs);
        reset = r; mmcm_locked = lk; soc_sck = sck; soc_cs = cs;
        @(posedge clk);
        model_edge(r, lk);
        #1;
        check_all(tag);
    endtask

    // Changes SoC pins between edges; pass-through must follow without a clock.
    task automatic poke(input string tag, input logic sck, input logic cs);
        soc_sck = sck; soc_cs = cs;
        #1;
        check_all(tag);
    endtask

    // Holds lock for n cycles from WAIT_LOCK and measures preamble edges and RUN entry.
    task automatic boot_run(input string tag, input int n, output int rises1, output int run1,
                            output int rises2, output int run2);
        logic p1, p2;
        rises1 = 0; rises2 = 0; run1 = -1; run2 = -1;
        p1 = u1_usr_cclk; p2 = u2_usr_cclk;
        for (int k = 1; k <= n; k++) begin
            step(tag, 1'b0, 1'b1, 1'b0, 1'b1);
            if (!u1_soc_rst_n && u1_usr_cclk && !p1) rises1++;
            if (!u2_soc_rst_n && u2_usr_cclk && !p2) rises2++;
            if (u1_soc_rst_n && run1 < 0) run1 = k;
            if (u2_soc_rst_n && run2 < 0) run2 = k;
            if (tag == "boot" && k <= 12) chk($sformatf("boot pattern c%0d", k), int'(u1_usr_cclk), int'(pat[k-1]));
            p1 = u1_usr_cclk; p2 = u2_usr_cclk;
        end
    endtask

    initial begin
        int r1, c1, r2, c2, rises;
        total = 0; passed = 0;
        for (int i = 0; i < 2; i++) begin mode[i] = M_WAIT; t[i] = 0; pd[i] = 0; end
        reset = 1'b1; mmcm_locked = 1'b1; soc_sck = 1'b0; soc_cs = 1'b1;

        step("reset", 1'b1, 1'b1, 1'b1, 1'b0);
        step("reset", 1'b1, 1'b1, 1'b0, 1'b0);

        // Nominal boot with default and minimal parameters side by side.
        boot_run("boot", 35, r1, c1, r2, c2);
        chk("boot u1 rising edges", r1, 3);
        chk("boot u1 run cycle", c1, 29);
        chk("sweep u2 rising edges", r2, 1);
        chk("sweep u2 run cycle", c2, 4);

        // Pass-through in RUN, including mid-cycle pin changes.
        for (int k = 0; k < 6; k++) begin
            poke("pass poke", 1'($urandom), 1'b0);
            chk("pass usr follows sck", int'(u1_usr_cclk), int'(soc_sck));
            step("pass step", 1'b0, 1'b1, 1'($urandom), 1'($urandom));
        end

        // Single-cycle lock loss in RUN, then relock skips the preamble.
        step("run drop", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("run drop rst_n", int'(u1_soc_rst_n), 0);
        chk("run drop qspi_cs", int'(u1_qspi_cs), 1);
        chk("run drop usr_cclk", int'(u1_usr_cclk), 0);
        rises = 0; c1 = -1;
        for (int k = 1; k <= 20; k++) begin
            logic prev;
            prev = u1_usr_cclk;
            step("relock", 1'b0, 1'b1, 1'($urandom), 1'($urandom));
            if (!u1_soc_rst_n && u1_usr_cclk && !prev) rises++;
            if (u1_soc_rst_n && c1 < 0) c1 = k;
        end
        chk("relock toggles", rises, 0);
        chk("relock run cycle", c1, 17);

        // Lock loss after two preamble rising edges.
        step("pre reset", 1'b1, 1'b1, 1'b0, 1'b1);
        boot_run("pre part", 8, r1, c1, r2, c2);
        chk("pre partial edges", r1, 2);
        step("pre drop", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre drop usr_cclk", int'(u1_usr_cclk), 0);
        boot_run("pre relock", 35, r1, c1, r2, c2);
        chk("pre relock edges", r1, 3);
        chk("pre relock run cycle", c1, 29);

        // Reset while in RUN replays everything.
        step("run reset", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("run reset usr_cclk", int'(u1_usr_cclk), 0);
        chk("run reset seq_done", int'(u1_seq_done), 0);
        boot_run("post reset", 35, r1, c1, r2, c2);
        chk("post reset edges", r1, 3);
        chk("post reset run cycle", c1, 29);

        // Random lock drops, resets and SoC pin activity.
        for (int k = 0; k < 400; k++) begin
            step("random", 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 24) != 0),
                 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) poke("random poke", 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
